// File: rtl/lfsr_pkg.sv
// Constants and helpers shared by the 64-bit LFSR keystream generator and its
// receive-side sync checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 64;
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic tap_parity(input logic [LFSR_W-1:0] win,
                                      input logic [LFSR_W-1:0] taps);
    return ^(win & taps);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_window_64bit.sv
// 64-bit receive window (bit 0 = newest) with a selectable load bit
// and a combinational prediction of the next keystream bit.
module lfsr_window_64bit
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic shift_i,
  input  logic sel_pred_i,
  input  logic bit_i,
  output logic pred_o,
  output logic fill_zero_o
);

  logic [LFSR_W-1:0] win_q;
  logic [LFSR_W-1:0] win_d;
  logic              pred_s;
  logic              in_bit_s;

  // Prediction, load-bit selection and next window value
  always_comb begin
    pred_s      = tap_parity(win_q, TAPS);
    in_bit_s    = sel_pred_i ? pred_s : bit_i;
    // Would the window become the lock-up value if bit_i were shifted in now?
    fill_zero_o = ~|{win_q[LFSR_W-2:0], bit_i};
    if (shift_i) begin
      win_d = {win_q[LFSR_W-2:0], in_bit_s};
    end else begin
      win_d = win_q;
    end
  end

  assign pred_o = pred_s;

  // Window register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= {LFSR_W{1'b0}};
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/lfsr_sync_checker_64bit.sv
// Self-synchronising keystream checker: hunts for a valid 64-bit window,
// confirms it, then flywheels on its own prediction and counts bit errors.
module lfsr_sync_checker_64bit
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS       = DEFAULT_TAPS,
  parameter int unsigned       LOCK_CNT   = 16,
  parameter int unsigned       ERR_THRESH = 8,
  parameter int unsigned       ERR_WIN    = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_bit,
  input  logic        i_clr,
  output logic [1:0]  o_state,
  output logic        o_locked,
  output logic        o_err,
  output logic [31:0] o_err_cnt,
  output logic [31:0] o_bit_cnt
);

  localparam int unsigned WIN_W = $clog2(ERR_WIN);
  localparam logic [7:0]       LOCK_CNT_V   = 8'(LOCK_CNT);
  localparam logic [WIN_W:0]   ERR_THRESH_V = (WIN_W+1)'(ERR_THRESH);
  localparam logic [WIN_W-1:0] WIN_LAST     = {WIN_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_ONE      = {{(WIN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [5:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W:0]   win_err_q, win_err_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [31:0]      bit_cnt_q, bit_cnt_d;

  logic             pred_s;
  logic             fill_zero_s;
  logic             mismatch_s;
  logic [WIN_W:0]   win_err_inc_s;

  lfsr_window_64bit #(.TAPS(TAPS)) u_window (
    .clk_i       (i_clk),
    .rst_ni      (i_rst),
    .shift_i     (i_valid),
    .sel_pred_i  (state_q == ST_LOCKED),
    .bit_i       (i_bit),
    .pred_o      (pred_s),
    .fill_zero_o (fill_zero_s)
  );

  assign mismatch_s    = i_bit ^ pred_s;
  assign win_err_inc_s = win_err_q + {{WIN_W{1'b0}}, mismatch_s};

  // Next-state logic for the acquisition FSM and statistics counters
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    if (i_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (fill_q == 6'd63) begin
            fill_d = 6'd0;
            if (!fill_zero_s) begin
              state_d = ST_CHECK;
              match_d = 8'd0;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            fill_d = fill_q + 6'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch_s) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
            fill_d  = 6'd0;
          end else if (match_q + 8'd1 == LOCK_CNT_V) begin
            state_d   = ST_LOCKED;
            win_cnt_d = {WIN_W{1'b0}};
            win_err_d = {(WIN_W+1){1'b0}};
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          err_d     = mismatch_s;
          win_cnt_d = win_cnt_q + WIN_ONE;
          // Threshold is tested before the window wrap so it wins on a tie
          if (win_err_inc_s >= ERR_THRESH_V) begin
            state_d   = ST_HUNT;
            fill_d    = 6'd0;
            win_err_d = {(WIN_W+1){1'b0}};
          end else if (win_cnt_q == WIN_LAST) begin
            win_err_d = {(WIN_W+1){1'b0}};
          end else begin
            win_err_d = win_err_inc_s;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = 6'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (i_clr) begin
      err_cnt_d = 32'd0;
      bit_cnt_d = 32'd0;
    end else if (i_valid && (state_q != ST_HUNT)) begin
      err_cnt_d = err_d ? sat_inc32(err_cnt_q) : err_cnt_q;
      bit_cnt_d = sat_inc32(bit_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, counter and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_HUNT;
      fill_q    <= 6'd0;
      match_q   <= 8'd0;
      win_cnt_q <= {WIN_W{1'b0}};
      win_err_q <= {(WIN_W+1){1'b0}};
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= 32'd0;
      bit_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign o_state   = state_q;
  assign o_locked  = locked_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_sync_checker_64bit.sv
// Scoreboard bench for lfsr_sync_checker_64bit: the driver queues the expected
// outputs of each valid beat, a monitor pops and compares them one clock later.
module tb_lfsr_sync_checker_64bit;

  localparam logic [63:0] GEN_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED     = 64'h0123_4567_89AB_CDEF;
  localparam logic [1:0]  H = 2'd0;
  localparam logic [1:0]  C = 2'd1;
  localparam logic [1:0]  L = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  state;
  logic        locked;
  logic        err;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;

  lfsr_sync_checker_64bit dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_valid   (valid),
    .i_bit     (bit_in),
    .i_clr     (clr),
    .o_state   (state),
    .o_locked  (locked),
    .o_err     (err),
    .o_err_cnt (err_cnt),
    .o_bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic        er;
    logic [31:0] ec;
    logic [31:0] bc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_x;
  int          total = 0;
  int          bad = 0;
  string       scen = "reset";
  logic [63:0] gen;
  logic [1:0]  exp_state;
  logic [31:0] exp_ec;
  logic [31:0] exp_bc;
  logic        took;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", scen, name, act, expv, $time);
    end
  endtask

  task automatic gen_bit(output logic b);
    b   = ^(gen & GEN_TAPS);
    gen = {gen[62:0], b};
  endtask

  // One valid beat; st/e are the hand-derived state and error pulse after it.
  task automatic send(input logic b, input logic [1:0] st, input logic e, input logic c);
    exp_t x;
    if (c) begin
      exp_ec = 32'd0;
      exp_bc = 32'd0;
    end else begin
      if (exp_state != H) exp_bc++;
      if (e) exp_ec++;
    end
    exp_state = st;
    x.st = st; x.lk = (st == L); x.er = e; x.ec = exp_ec; x.bc = exp_bc;
    q.push_back(x);
    valid = 1'b1; bit_in = b; clr = c;
    @(negedge clk);
    valid = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_err", 32'(err), 32'd0);
      check("idle_state", 32'(state), 32'(exp_state));
    end
  endtask

  // Asynchronous reset, checked before any clock edge can intervene.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    check("rst_bit_cnt", bit_cnt, 32'd0);
    check("sb_drained", 32'(q.size()), 32'd0);
    q.delete();
    exp_state = H; exp_ec = 32'd0; exp_bc = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) took <= 1'b0;
    else        took <= valid;
  end

  always @(negedge clk) begin
    if (took) begin
      check("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        mon_x = q.pop_front();
        check("state", 32'(state), 32'(mon_x.st));
        check("locked", 32'(locked), 32'(mon_x.lk));
        check("err", 32'(err), 32'(mon_x.er));
        check("err_cnt", err_cnt, mon_x.ec);
        check("bit_cnt", bit_cnt, mon_x.bc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    logic inv;
    gen = SEED;
    exp_state = H; exp_ec = 32'd0; exp_bc = 32'd0;
    do_reset();

    scen = "acquire";
    for (int k = 1; k <= 100; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : ((k < 80) ? C : L), 1'b0, 1'b0);
    end
    check("acq_bit_cnt_final", bit_cnt, 32'd36);

    scen = "sparse_err";
    for (int j = 1; j <= 300; j++) begin
      gen_bit(b);
      inv = ((j % 100) == 50);
      send(b ^ inv, L, inv, 1'b0);
    end
    check("sparse_err_cnt_final", err_cnt, 32'd3);

    scen = "burst_loss";
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : ((k < 80) ? C : L), 1'b0, 1'b0);
    end
    for (int j = 1; j <= 40; j++) begin
      gen_bit(b);
      inv = ((j % 5) == 0);
      send(b ^ inv, (j == 40) ? H : L, inv, 1'b0);
    end
    for (int k = 1; k <= 80; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : ((k < 80) ? C : L), 1'b0, 1'b0);
    end
    check("burst_relocked", 32'(locked), 32'd1);

    scen = "zero_fill";
    do_reset();
    for (int k = 1; k <= 64; k++) send(1'b0, H, 1'b0, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : ((k < 80) ? C : L), 1'b0, 1'b0);
    end

    scen = "check_err";
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      gen_bit(b);
      inv = (k == 70);
      send(b ^ inv, (k < 64) ? H : ((k < 70) ? C : H), inv, 1'b0);
    end
    for (int k = 1; k <= 65; k++) begin
      gen_bit(b);
      if (k < 64)       send(b, H, 1'b0, 1'b0);
      else if (k == 64) send(b, C, 1'b0, 1'b0);
      else              send(~b, H, 1'b1, 1'b1);
    end
    check("clr_err_cnt_final", err_cnt, 32'd0);

    scen = "slow_strobe";
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : C, 1'b0, 1'b0);
      idle(7);
    end
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      gen_bit(b);
      send(b, (k < 64) ? H : ((k < 80) ? C : L), 1'b0, 1'b0);
      idle(7);
    end
    check("slow_bit_cnt_final", bit_cnt, 32'd36);

    @(negedge clk);
    check("sb_empty_end", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
